mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MIPS MEM-stage load/store sequencer, directly upstream of the word-wide data memory (DM).
//  - Accepts one load/store per handshake from the EX/MEM pipeline register.
//  - Drives the DM word port: WE, Adr, WDATA out; registered Rdata back, valid 1 cycle after the read address.
//  - Byte/halfword loads: extracts the lane, then sign- or zero-extends it.
//  - Byte/halfword stores: read-modify-write, because DM writes whole words only.
// PARAMETERS
//  AW     32  address width; DM is word-addressed via Adr>>2 internally
//  DW     32  data width; fixed at 32 for MIPS
// PORTS
//  CLK         in   1   clock, rising edge
//  RST_N       in   1   asynchronous, active-low reset
//  req_valid   in   1   request present
//  req_ready   out  1   unit idle, can accept
//  req_store   in   1   1=store (SB/SH/SW), 0=load
//  req_size    in   2   00 byte, 01 half, 10 word, 11 reserved (treated as word)
//  req_signed  in   1   loads only: 1=sign-extend (LB/LH), 0=zero-extend (LBU/LHU)
//  req_addr    in   AW  byte address
//  req_wdata   in   DW  store data, right-justified
//  resp_valid  out  1   one-cycle pulse; load data or store done; no backpressure
//  resp_data   out  DW  formatted load data; 0 for stores
//  resp_err    out  1   misaligned access (only with MAU_MISALIGN_TRAP_EN)
//  dm_we       out  1   DM write enable
//  dm_adr      out  AW  DM byte address, low 2 bits always 0
//  dm_wdata    out  DW  DM write word
//  dm_rdata    in   DW  DM read word, registered in DM
// BEHAVIOUR
//  - Reset (async, RST_N=0): state IDLE.
//    - req_ready=1; resp_valid=0; resp_data=0; resp_err=0; dm_we=0; dm_adr=0; dm_wdata=0.
//    - Clears dm_we immediately, aborting any in-flight write; held requests are discarded.
//  - All outputs are registered or decoded from state/registers only. No comb path from req_* to dm_*.
//  - Accept: req_valid&&req_ready at an edge.
//    - Latches store, size, signed, addr, wdata.
//    - req_ready=1 only in IDLE.
//  - FSM:
//    - IDLE:    accept -> RD (load), WR (word store), RMW_RD (sub-word store).
//    - RD:      dm_we=0, dm_adr={addr[31:2],2'b00} -> RD_CAP.
//    - RD_CAP:  lane select from dm_rdata (little-endian, byte k = bits 8k+7:8k) -> extend into resp_data -> RESP.
//    - RMW_RD:  same as RD -> RMW_MRG.
//    - RMW_MRG: replace the addressed byte/half of dm_rdata with wdata[7:0]/[15:0] -> merged word in dm_wdata reg -> WR.
//    - WR:      dm_we=1 for exactly one cycle; word store writes wdata unchanged -> RESP.
//    - RESP:    resp_valid=1 for one cycle -> IDLE.
//  - Latency, accept edge to resp_valid high (cycles): load 3, word store 2, sub-word store 4.
//    Back-to-back throughput: one op per latency+1 cycles.
//  - dm_we is 0 in every state except WR. DM Rdata returning 0 after a write is never consumed.
//  - Alignment (without macro): low address bits are ignored per size.
//    - Half uses addr[1]; word uses addr[1:0]=00.
//    - Byte lane = addr[1:0]; half lane = addr[1].
//  - req_size=11 behaves exactly as word.
// CONFIGURATION
//  MAU_MISALIGN_TRAP_EN defined:
//    - resp_err is driven.
//    - Half with addr[0]=1, or word with addr[1:0]!=0: IDLE -> RESP directly.
//    - No DM access, dm_we stays 0, resp_data=0, resp_err=1 during the resp_valid pulse.
//  MAU_MISALIGN_TRAP_EN undefined:
//    - resp_err tied 0.
//    - Misaligned requests are silently force-aligned as above.
// STRUCTURE
//  - Package mau_pkg:
//    - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
//    - State enum mau_state_t (IDLE,RD,RD_CAP,RMW_RD,RMW_MRG,WR,RESP).
//    - Latency constants for the bench.
//  - Sub-module mau_lane_fmt (combinational): load extract+extend, and store merge.
//    Inputs: word, addr[1:0], size, signed, wdata.
// TESTING
//  - Reset: RST_N low mid-WR -> dm_we falls without a clock, all outputs 0, req_ready=1.
//  - LW addr 0x10, DM word 0xDEADBEEF -> dm_adr=0x10 in RD, resp_data=0xDEADBEEF, resp_valid 3 cycles after accept.
//  - LB addr 0x13 signed on 0x80FF0011 -> 0xFFFFFF80; LBU -> 0x00000080; LH addr 0x12 signed -> 0xFFFF80FF.
//  - SB addr 0x21 data 0xAB over word 0x11223344 -> one read, one write 0x1122AB44, resp_valid 4 cycles after accept.
//  - SW addr 0x30 0xCAFEF00D, then LW 0x30 back-to-back -> 0xCAFEF00D; req_ready low during each op.
//  - LH addr 0x41: with MAU_MISALIGN_TRAP_EN -> no DM access, resp_err=1, resp_data=0;
//    without it -> reads half at 0x40.

Source files
------------

// File: rtl/mau_pkg.sv
// -----------------------------------------------------------------------------
// mau_pkg
// Shared definitions for the MEM-stage load/store sequencer (mem_access_unit):
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD / SZ_RSVD)
//   - sequencer state enum mau_state_t
//   - accept-to-response latencies, in cycles, for each kind of operation
//   - small decode helpers for sub-word detection and alignment checking
// Optional feature macro used by the importing files: MAU_MISALIGN_TRAP_EN.
// -----------------------------------------------------------------------------
package mau_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;  // behaves exactly as SZ_WORD

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_CAP  = 3'd2,
    RMW_RD  = 3'd3,
    RMW_MRG = 3'd4,
    WR      = 3'd5,
    RESP    = 3'd6
  } mau_state_t;

  // Cycles from the accepting clock edge until resp_valid is high, counting
  // the cycle that follows the accept edge as cycle 1.
  localparam int LAT_LOAD       = 3;
  localparam int LAT_STORE_WORD = 2;
  localparam int LAT_STORE_SUB  = 4;
  localparam int LAT_TRAP       = 1;

  // Byte and halfword stores need a read-modify-write; word (and the
  // reserved encoding) stores write straight through.
  function automatic logic is_sub_word(input logic [1:0] size);
    return (size == SZ_BYTE) || (size == SZ_HALF);
  endfunction

  // Natural alignment check: halves need addr[0]==0, words addr[1:0]==0.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (size == SZ_HALF)
      mis = addr_lo[0];
    else if (size[1])
      mis = (addr_lo != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/mau_lane_fmt.sv
// -----------------------------------------------------------------------------
// mau_lane_fmt
// Purely combinational lane formatter for the MEM-stage sequencer.
//   - Load path : picks the addressed byte/half out of a DM word (little-endian,
//                 byte k = bits 8k+7:8k) and sign- or zero-extends it.
//   - Store path: overlays the right-justified store data onto the DM word at
//                 the addressed byte/half lane (read-modify-write merge).
// Ports:
//   word       in  32  DM read word
//   addr       in   2  low byte-address bits (lane select)
//   size       in   2  SZ_BYTE / SZ_HALF / SZ_WORD / SZ_RSVD
//   sgn        in   1  1 = sign-extend loads, 0 = zero-extend
//   wdata      in  32  right-justified store data
//   load_data  out 32  formatted load result
//   merge_data out 32  word to write back to DM
// -----------------------------------------------------------------------------
module mau_lane_fmt
  import mau_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Lane extraction. Halfword lanes only look at addr[1]; addr[0] is
  // dropped, which is how misaligned halves get force-aligned.
  always_comb begin
    lane_b = word[7:0];
    case (addr)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = addr[1] ? word[31:16] : word[15:0];
  end

  // Load formatting.
  always_comb begin
    load_data = word;
    case (size)
      SZ_BYTE: load_data = {{24{sgn & lane_b[7]}}, lane_b};
      SZ_HALF: load_data = {{16{sgn & lane_h[15]}}, lane_h};
      default: load_data = word;
    endcase
  end

  // Store merge. Word-sized stores ignore the old contents entirely.
  always_comb begin
    merge_data = word;
    case (size)
      SZ_BYTE: begin
        case (addr)
          2'd0:    merge_data[7:0]   = wdata[7:0];
          2'd1:    merge_data[15:8]  = wdata[7:0];
          2'd2:    merge_data[23:16] = wdata[7:0];
          default: merge_data[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (addr[1])
          merge_data[31:16] = wdata[15:0];
        else
          merge_data[15:0]  = wdata[15:0];
      end
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// MIPS MEM-stage load/store sequencer sitting in front of a word-wide data
// memory (DM) whose read data is registered (valid one cycle after address).
// One request is taken per handshake; byte/half loads are lane-extracted and
// extended, byte/half stores are done as read-modify-write.
//
// Handshake: a request is taken at a rising CLK edge where req_valid and
// req_ready are both high. req_ready is high only while the unit is IDLE, so
// at most one operation is in flight. resp_valid is a single-cycle pulse with
// no backpressure; resp_data carries load data (0 for stores).
//
// All outputs come straight from registers; nothing on req_* reaches dm_*
// combinationally.
//
// Optional feature macro: MAU_MISALIGN_TRAP_EN
//   defined   : misaligned half/word requests skip DM and respond with
//               resp_err=1, resp_data=0 one cycle after accept.
//   undefined : resp_err is tied 0; misaligned requests are force-aligned.
//
// Ports:
//   CLK, RST_N                 clock (rising edge), async active-low reset
//   req_valid/req_ready        request handshake
//   req_store, req_size,
//   req_signed, req_addr,
//   req_wdata                  request fields, latched on accept
//   resp_valid, resp_data,
//   resp_err                   response pulse
//   dm_we, dm_adr, dm_wdata    DM word port (dm_adr low two bits always 0)
//   dm_rdata                   DM registered read word
//   dbg_state                  current sequencer state (mau_state_t)
// -----------------------------------------------------------------------------
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_store,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_data,
  output logic          resp_err,
  output logic          dm_we,
  output logic [AW-1:0] dm_adr,
  output logic [DW-1:0] dm_wdata,
  input  logic [DW-1:0] dm_rdata,
  output logic [2:0]    dbg_state
);

  mau_state_t    state;
  logic [1:0]    r_size;
  logic          r_sgn;
  logic [1:0]    r_addr_lo;
  logic [DW-1:0] r_wdata;

  logic          accept;
  logic          trap_now;
  logic [DW-1:0] fmt_load;
  logic [DW-1:0] fmt_merge;

  assign accept    = req_valid && req_ready;
  assign dbg_state = state;

  // Formatter always works on the latched request and the live DM read word;
  // its results are only consumed in RD_CAP / RMW_MRG, when dm_rdata holds
  // the word addressed in the preceding RD / RMW_RD cycle.
  mau_lane_fmt u_lane_fmt (
    .word       (dm_rdata),
    .addr       (r_addr_lo),
    .size       (r_size),
    .sgn        (r_sgn),
    .wdata      (r_wdata),
    .load_data  (fmt_load),
    .merge_data (fmt_merge)
  );

`ifdef MAU_MISALIGN_TRAP_EN
  logic err_q;

  assign trap_now = is_misaligned(req_size, req_addr[1:0]);

  // Error flag rides alongside resp_valid: set only on a trapped accept,
  // cleared as the RESP pulse ends.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      err_q <= 1'b0;
    else if (state == IDLE && accept && trap_now)
      err_q <= 1'b1;
    else if (state == RESP)
      err_q <= 1'b0;
  end

  assign resp_err = err_q;
`else
  assign trap_now = 1'b0;
  assign resp_err = 1'b0;
`endif

  // Sequencer. Every output is a register updated here; dm_we is set only on
  // entry to WR and cleared on the way out, so it is high for exactly one
  // cycle per store.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      dm_we      <= 1'b0;
      dm_adr     <= '0;
      dm_wdata   <= '0;
      r_size     <= SZ_BYTE;
      r_sgn      <= 1'b0;
      r_addr_lo  <= 2'b00;
      r_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            r_size    <= req_size;
            r_sgn     <= req_signed;
            r_addr_lo <= req_addr[1:0];
            r_wdata   <= req_wdata;
            req_ready <= 1'b0;
            if (trap_now) begin
              // Trapped access: straight to the response, DM untouched.
              resp_valid <= 1'b1;
              resp_data  <= '0;
              state      <= RESP;
            end else begin
              dm_adr <= {req_addr[AW-1:2], 2'b00};
              if (!req_store) begin
                state <= RD;
              end else if (is_sub_word(req_size)) begin
                state <= RMW_RD;
              end else begin
                dm_wdata <= req_wdata;
                dm_we    <= 1'b1;
                state    <= WR;
              end
            end
          end
        end

        // Address is already on dm_adr; DM returns the word next cycle.
        RD:     state <= RD_CAP;
        RMW_RD: state <= RMW_MRG;

        RD_CAP: begin
          resp_data  <= fmt_load;
          resp_valid <= 1'b1;
          state      <= RESP;
        end

        RMW_MRG: begin
          dm_wdata <= fmt_merge;
          dm_we    <= 1'b1;
          state    <= WR;
        end

        WR: begin
          dm_we      <= 1'b0;
          resp_valid <= 1'b1;
          resp_data  <= '0;
          state      <= RESP;
        end

        RESP: begin
          resp_valid <= 1'b0;
          resp_data  <= '0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end

        default: begin
          dm_we      <= 1'b0;
          resp_valid <= 1'b0;
          resp_data  <= '0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Bench for mem_access_unit: a word-wide registered DM model, a byte-array
// reference memory, a table of directed load/store vectors, hand-written
// multi-cycle sequences (RMW store, back-to-back ops, reset mid-write) and a
// randomized run checked against the byte-level reference model.
// Honours MAU_MISALIGN_TRAP_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

`ifdef MAU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  // ---------------- DUT ----------------
  logic        req_valid, req_ready, req_store, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_data;
  logic        dm_we;
  logic [31:0] dm_adr, dm_wdata, dm_rdata;
  logic [2:0]  dbg_state;

  mem_access_unit dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .dm_we      (dm_we),
    .dm_adr     (dm_adr),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata),
    .dbg_state  (dbg_state)
  );

  // ---------------- DM model (registered read, 256 words) ----------------
  logic [31:0] dm_mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = 8'd0;
  logic [31:0] pl_data = 32'd0;

  always @(posedge CLK) begin
    if (pl_en)
      dm_mem[pl_idx] <= pl_data;
    else if (dm_we)
      dm_mem[dm_adr[9:2]] <= dm_wdata;
    dm_rdata <= dm_mem[dm_adr[9:2]];
  end

  // ---------------- reference model: byte-addressed memory ----------------
  logic [7:0] rmem [0:1023];

  function automatic logic ref_trap(input logic [1:0] sz, input logic [1:0] lo);
    logic mis;
    mis = (sz == 2'b01 && lo[0]) || (sz[1] && lo != 2'b00);
    return TRAP_EN && mis;
  endfunction

  function automatic logic [31:0] ref_word(input int base);
    return 32'(rmem[base]) + (32'(rmem[base+1]) << 8) +
           (32'(rmem[base+2]) << 16) + (32'(rmem[base+3]) << 24);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg,
                                           input logic [9:0] ad);
    int base;
    int a;
    logic [31:0] v;
    base = int'(ad) & 32'h3FC;
    if (sz == 2'b00) begin
      v = 32'(rmem[ad]);
      if (sg && v >= 128) v = v - 256;
    end else if (sz == 2'b01) begin
      a = base + (ad[1] ? 2 : 0);
      v = 32'(rmem[a]) + 256 * 32'(rmem[a+1]);
      if (sg && v >= 32768) v = v - 65536;
    end else begin
      v = ref_word(base);
    end
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [9:0] ad,
                           input logic [31:0] wd);
    int base;
    int a;
    base = int'(ad) & 32'h3FC;
    if (sz == 2'b00) begin
      rmem[ad] = wd[7:0];
    end else if (sz == 2'b01) begin
      a = base + (ad[1] ? 2 : 0);
      rmem[a]   = wd[7:0];
      rmem[a+1] = wd[15:8];
    end else begin
      for (int i = 0; i < 4; i++) rmem[base+i] = 8'((wd >> (8 * i)) & 32'hFF);
    end
  endtask

  // ---------------- scoreboard counters ----------------
  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [9:0] ad, input logic [31:0] w);
    @(negedge CLK);
    pl_en = 1'b1; pl_idx = ad[9:2]; pl_data = w;
    for (int i = 0; i < 4; i++) rmem[(int'(ad) & 32'h3FC) + i] = 8'((w >> (8 * i)) & 32'hFF);
    @(negedge CLK);
    pl_en = 1'b0;
  endtask

  // Results of the last do_op
  int          got_lat;
  logic [31:0] got_data;
  logic        got_err;
  int          got_writes;
  logic [31:0] last_wword, last_wadr, first_adr;
  logic        ready_low;
  time         t_acc;

  // Called at a negedge. Presents the request, waits (bounded) for the
  // accept edge, then samples every following negedge until resp_valid.
  task automatic do_op(input logic st, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd);
    int n;
    int k;
    req_valid = 1'b1; req_store = st; req_size = sz; req_signed = sg;
    req_addr = ad; req_wdata = wd;
    got_lat = -1; got_data = 32'hx; got_err = 1'bx; got_writes = 0;
    ready_low = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge CLK); n++; end
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge CLK);
    t_acc = $time;
    @(negedge CLK);
    // Scramble request fields after accept; the unit must use latched copies.
    req_valid = 1'b0; req_store = 1'($urandom); req_size = 2'($urandom);
    req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    first_adr = dm_adr;
    k = 1;
    while (k <= 12) begin
      if (req_ready) ready_low = 1'b0;
      if (dm_we) begin
        got_writes++;
        last_wword = dm_wdata;
        last_wadr  = dm_adr;
      end
      if (resp_valid) begin
        got_lat  = k;
        got_data = resp_data;
        got_err  = resp_err;
        break;
      end
      @(negedge CLK);
      k++;
    end
  endtask

  // Runs one op and scores it; keeps the reference memory in step.
  task automatic exec(input string nm, input logic st, input logic [1:0] sz,
                      input logic sg, input logic [31:0] ad, input logic [31:0] wd,
                      input logic [31:0] exp_data, input int exp_lat,
                      input logic exp_err, input logic exp_w);
    exp_q.push_back(exp_data);
    do_op(st, sz, sg, ad, wd);
    chk({nm, "_data"}, got_data, exp_q.pop_front());
    chk({nm, "_lat"}, 32'(got_lat), 32'(exp_lat));
    chk({nm, "_err"}, 32'(got_err), 32'(exp_err));
    chk({nm, "_nwr"}, 32'(got_writes), exp_w ? 32'd1 : 32'd0);
    chk({nm, "_busy"}, 32'(ready_low), 32'd1);
    if (exp_w) begin
      ref_store(sz, ad[9:0], wd);
      chk({nm, "_wadr"}, last_wadr, {ad[31:2], 2'b00});
      chk({nm, "_wword"}, last_wword, ref_word(int'(ad[9:0]) & 32'h3FC));
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [31:0] exp_data;
    int          exp_lat;
    logic        exp_err;
    logic        exp_w;
  } vec_t;

  vec_t tbl[$];

  initial begin
    time         t1;
    logic        st, sg, tr;
    logic [1:0]  sz;
    logic [31:0] ad, wd, ed;
    int          el;

    req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;

    // Reset state
    RST_N = 1'b0;
    @(negedge CLK); @(negedge CLK);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rvalid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_data, 32'd0);
    chk("rst_rerr", 32'(resp_err), 32'd0);
    chk("rst_we", 32'(dm_we), 32'd0);
    chk("rst_adr", dm_adr, 32'd0);
    chk("rst_wdata", dm_wdata, 32'd0);
    RST_N = 1'b1;

    // Fill DM and the reference with random words, then the named ones.
    for (int i = 0; i < 256; i++) preload(10'(i * 4), $urandom);
    preload(10'h10, 32'hDEADBEEF);
    preload(10'h20, 32'h11223344);
    preload(10'h40, 32'h87654321);
    preload(10'h60, 32'hA5A5A5A5);

    tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 3, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF0011, 32'h0,        2, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'hFFFFFF80, 3, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'h00000080, 3, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        32'hFFFF80FF, 3, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'h000080FF, 3, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b00, 1'b1, 32'h12, 32'h0,        32'hFFFFFFFF, 3, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b01, 1'b1, 32'h10, 32'h0,        32'h00000011, 3, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b11, 1'b1, 32'h10, 32'h0,        32'h80FF0011, 3, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h13, 32'h0,
                    TRAP_EN ? 32'h0 : 32'h80FF0011, TRAP_EN ? 1 : 3, TRAP_EN, 1'b0});
    tbl.push_back('{1'b0, 2'b01, 1'b1, 32'h41, 32'h0,
                    TRAP_EN ? 32'h0 : 32'h00004321, TRAP_EN ? 1 : 3, TRAP_EN, 1'b0});
    tbl.push_back('{1'b1, 2'b01, 1'b0, 32'h42, 32'hFFFF9988, 32'h0,        4, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h40, 32'h0,        32'h99884321, 3, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 2'b00, 1'b0, 32'h43, 32'h0000007E, 32'h0,        4, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h40, 32'h0,        32'h7E884321, 3, 1'b0, 1'b0});

    @(negedge CLK);
    for (int i = 0; i < tbl.size(); i++)
      exec($sformatf("vec%0d", i), tbl[i].st, tbl[i].sz, tbl[i].sg, tbl[i].ad,
           tbl[i].wd, tbl[i].exp_data, tbl[i].exp_lat, tbl[i].exp_err, tbl[i].exp_w);

    // SB into the middle of a word: one write of the merged word, latency 4.
    exec("sb21", 1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AB, 32'h0, 4, 1'b0, 1'b1);
    chk("sb21_merged", last_wword, 32'h1122AB44);
    exec("lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1122AB44, 3, 1'b0, 1'b0);
    chk("lw20_rd_adr", first_adr, 32'h20);

    // Back-to-back SW then LW: second accept lands latency+1 after the first.
    exec("sw30", 1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFEF00D, 32'h0, 2, 1'b0, 1'b1);
    t1 = t_acc;
    exec("lw30", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'hCAFEF00D, 3, 1'b0, 1'b0);
    chk("b2b_gap", 32'((t_acc - t1) / 10), 32'd3);

    // Reset in the middle of a word-store write cycle.
    req_valid = 1'b1; req_store = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h60; req_wdata = 32'h12345678;
    for (int n = 0; n < 20 && !req_ready; n++) @(negedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    chk("midwr_we_pre", 32'(dm_we), 32'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("midwr_we", 32'(dm_we), 32'd0);
    chk("midwr_ready", 32'(req_ready), 32'd1);
    chk("midwr_rvalid", 32'(resp_valid), 32'd0);
    chk("midwr_rdata", resp_data, 32'd0);
    chk("midwr_adr", dm_adr, 32'd0);
    chk("midwr_wdata", dm_wdata, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    exec("lw60", 1'b0, 2'b10, 1'b0, 32'h60, 32'h0, 32'hA5A5A5A5, 3, 1'b0, 1'b0);

    // Randomized ops against the byte-level reference.
    for (int i = 0; i < 150; i++) begin
      st = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      ad = 32'($urandom_range(0, 1023));
      wd = $urandom;
      tr = ref_trap(sz, ad[1:0]);
      ed = (st || tr) ? 32'h0 : ref_load(sz, sg, ad[9:0]);
      el = tr ? 1 : (st ? (sz[1] ? 2 : 4) : 3);
      exec($sformatf("rnd%0d", i), st, sz, sg, ad, wd, ed, el, tr, st && !tr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
